// File: rtl/seg_capture.sv
// Seven-segment bus monitor: recovers per-digit character codes from the multiplexed
// anode/cathode pins and assembles them into 16-bit frames with change detection.
module seg_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [6:0]  LED,
    output logic [3:0]  char_code,
    output logic [1:0]  digit_idx,
    output logic        digit_valid,
    output logic        sym_err,
    output logic [15:0] frame,
    output logic        frame_valid,
    output logic        frame_changed
);

    localparam logic [8:0] STABLE_LAST = 9'(STABLE_CYCLES);
    localparam bit         ONE_CYCLE   = (STABLE_CYCLES == 1);

    typedef enum logic [1:0] {StIdle, StCount, StHeld} state_t;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [3:0]  an_q;
    logic [6:0]  led_q;
    logic [3:0]  seen_q, seen_d;
    logic [15:0] prev_q;
    logic        first_q;

    logic        is_sel, is_blank, is_ill;
    logic [1:0]  sel_idx;
    logic [3:0]  dec_code;
    logic        dec_known, dec_off;
    logic        changed, load, go_idle, capture, ill_err, frame_done;
    logic [8:0]  cnt_inc;

    always_comb begin
        is_sel  = 1'b0;
        sel_idx = 2'd0;
        unique case (an)
            4'b1110: begin is_sel = 1'b1; sel_idx = 2'd0; end
            4'b1101: begin is_sel = 1'b1; sel_idx = 2'd1; end
            4'b1011: begin is_sel = 1'b1; sel_idx = 2'd2; end
            4'b0111: begin is_sel = 1'b1; sel_idx = 2'd3; end
            default: ;
        endcase
        is_blank = (an == 4'b1111);
        is_ill   = !is_sel && !is_blank;
    end

    always_comb begin
        dec_known = 1'b1;
        dec_code  = 4'h0;
        case (LED)
            7'b0000001: dec_code = 4'b1010;
            7'b1001111: dec_code = 4'b0000;
            7'b0010010: dec_code = 4'b1001;
            7'b0000110: dec_code = 4'b1111;
            7'b1100010: dec_code = 4'b0001;
            7'b0011000: dec_code = 4'b0010;
            7'b1111010: dec_code = 4'b0011;
            7'b1000111: dec_code = 4'b0101;
            7'b0010000: dec_code = 4'b0110;
            7'b1110010: dec_code = 4'b0111;
            7'b1110000: dec_code = 4'b1000;
            7'b1111110: dec_code = 4'b1101;
            default:    dec_known = 1'b0;
        endcase
        dec_off = (LED == 7'b1111111);
    end

    always_comb begin
        changed    = (an != an_q) || (LED != led_q);
        cnt_inc    = {1'b0, cnt_q} + 9'd1;
        load       = (state_q == StIdle) ? is_sel : (changed && is_sel);
        go_idle    = (state_q != StIdle) && changed && !is_sel;
        capture    = (load && ONE_CYCLE) ||
                     (state_q == StCount && !changed && cnt_inc == STABLE_LAST);
        // Illegal anodes flag only on first appearance, not while held.
        ill_err    = is_ill && (an != an_q);
        frame_done = (seen_q == 4'hF);

        seen_d = frame_done ? 4'h0 : seen_q;
        if (ill_err) begin
            seen_d = 4'h0;
        end
        if (capture) begin
            if (dec_known) begin
                seen_d[sel_idx] = 1'b1;
            end else if (dec_off) begin
                seen_d[sel_idx] = 1'b0;
            end else begin
                seen_d = 4'h0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= 8'd0;
            an_q          <= 4'b1111;
            led_q         <= 7'b1111111;
            seen_q        <= 4'h0;
            prev_q        <= 16'h0;
            first_q       <= 1'b1;
            char_code     <= 4'h0;
            digit_idx     <= 2'd0;
            digit_valid   <= 1'b0;
            sym_err       <= 1'b0;
            frame         <= 16'h0;
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
        end else begin
            an_q          <= an;
            led_q         <= LED;
            seen_q        <= seen_d;
            digit_valid   <= 1'b0;
            sym_err       <= ill_err;
            frame_valid   <= frame_done;
            frame_changed <= frame_done && ((frame != prev_q) || first_q);
            if (frame_done) begin
                prev_q  <= frame;
                first_q <= 1'b0;
            end

            if (capture) begin
                state_q <= StHeld;
                cnt_q   <= load ? 8'd1 : cnt_inc[7:0];
            end else if (load) begin
                state_q <= StCount;
                cnt_q   <= 8'd1;
            end else if (state_q == StCount && !changed) begin
                cnt_q   <= cnt_inc[7:0];
            end else if (go_idle) begin
                state_q <= StIdle;
            end

            if (capture) begin
                if (dec_known) begin
                    digit_valid                 <= 1'b1;
                    char_code                   <= dec_code;
                    digit_idx                   <= sel_idx;
                    frame[{sel_idx, 2'b00} +: 4] <= dec_code;
                end else if (!dec_off) begin
                    sym_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture: stability window, frame assembly, errors and reset.
module tb_seg_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  an;
    logic [6:0]  LED;
    logic [3:0]  char_code;
    logic [1:0]  digit_idx;
    logic        digit_valid;
    logic        sym_err;
    logic [15:0] frame;
    logic        frame_valid;
    logic        frame_changed;

    int tests = 0;
    int fails = 0;

    int          dv_n, se_n, fv_n;
    logic [3:0]  last_code;
    logic [1:0]  last_idx;
    logic [15:0] last_frame;
    logic        last_fc;

    localparam logic [6:0] S_1 = 7'b1001111, S_O = 7'b1100010, S_P = 7'b0011000,
                           S_R = 7'b1111010, S_2 = 7'b0010010, S_T = 7'b1110000,
                           S_E = 7'b0010000, S_C = 7'b1110010, S_J = 7'b1000111,
                           S_DASH = 7'b1111110, S_3 = 7'b0000110, S_0 = 7'b0000001,
                           S_OFF = 7'b1111111, S_BAD = 7'b0101010;

    seg_capture #(.STABLE_CYCLES(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .an            (an),
        .LED           (LED),
        .char_code     (char_code),
        .digit_idx     (digit_idx),
        .digit_valid   (digit_valid),
        .sym_err       (sym_err),
        .frame         (frame),
        .frame_valid   (frame_valid),
        .frame_changed (frame_changed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (digit_valid) begin
            dv_n++;
            last_code = char_code;
            last_idx  = digit_idx;
        end
        if (sym_err) se_n++;
        if (frame_valid) begin
            fv_n++;
            last_frame = frame;
            last_fc    = frame_changed;
        end
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] l, input int n);
        an  = a;
        LED = l;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr();
        dv_n = 0; se_n = 0; fv_n = 0;
    endtask

    task automatic do_reset();
        an = 4'b1111; LED = S_OFF;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clr();
    endtask

    initial begin
        clr();
        last_code = 0; last_idx = 0; last_frame = 0; last_fc = 0;
        do_reset();
        check("reset_outputs",
              {char_code, 2'b0, digit_idx, digit_valid, sym_err, frame_valid, frame_changed, frame},
              32'h0);

        // Window of 4: pulse lands on the 4th edge.
        an = 4'b1110; LED = S_1;
        tick(); tick(); tick();
        check("dv_early", dv_n, 0);
        tick();
        check("dv_on_time", digit_valid, 1);
        check("code_one", char_code, 4'b0000);
        check("idx_zero", digit_idx, 2'd0);
        clr();
        hold(4'b1110, S_1, 20);
        check("no_recapture", dv_n, 0);

        // Short hold then blank.
        clr();
        hold(4'b1110, S_P, 3);
        hold(4'b1111, S_P, 3);
        check("short_dv", dv_n, 0);
        check("short_err", se_n, 0);

        // First frame "1oPr".
        do_reset();
        hold(4'b0111, S_1, 6);
        hold(4'b1011, S_O, 6);
        hold(4'b1101, S_P, 6);
        hold(4'b1110, S_R, 6);
        check("f1_dv", dv_n, 4);
        check("f1_fv", fv_n, 1);
        check("f1_frame", last_frame, 16'h0123);
        check("f1_changed", last_fc, 1);

        clr();
        hold(4'b0111, S_1, 6);
        hold(4'b1011, S_O, 6);
        hold(4'b1101, S_P, 6);
        hold(4'b1110, S_R, 6);
        check("f2_fv", fv_n, 1);
        check("f2_frame", last_frame, 16'h0123);
        check("f2_unchanged", last_fc, 0);

        // Scroll to "oPro".
        clr();
        hold(4'b0111, S_O, 6);
        hold(4'b1011, S_P, 6);
        hold(4'b1101, S_R, 6);
        hold(4'b1110, S_O, 6);
        check("f3_frame", last_frame, 16'h1231);
        check("f3_changed", last_fc, 1);

        clr();
        hold(4'b1110, S_2, 6);
        check("two_code", last_code, 4'b1001);
        check("two_idx", last_idx, 2'd0);

        // Unknown pattern clears seen; digit 0 from above must not count.
        clr();
        hold(4'b1101, S_BAD, 6);
        check("bad_err", se_n, 1);
        check("bad_no_dv", dv_n, 0);
        check("bad_code_hold", char_code, 4'b1001);
        hold(4'b0111, S_T, 6);
        hold(4'b1011, S_E, 6);
        hold(4'b1101, S_C, 6);
        check("bad_no_frame", fv_n, 0);
        hold(4'b1110, S_J, 6);
        check("bad_fv", fv_n, 1);
        check("bad_frame", last_frame, 16'h8675);
        check("bad_changed", last_fc, 1);

        // Illegal anodes: single pulse, one cycle after first seen.
        clr();
        an = 4'b1100;
        tick();
        check("ill_pulse", sym_err, 1);
        hold(4'b1100, S_J, 6);
        check("ill_once", se_n, 1);

        // Reset in COUNT at count 3.
        hold(4'b1111, S_OFF, 2);
        hold(4'b1110, S_1, 3);
        reset = 1'b1;
        #1;
        check("mid_reset_outputs",
              {char_code, 2'b0, digit_idx, digit_valid, sym_err, frame_valid, frame_changed, frame},
              32'h0);
        tick();
        reset = 1'b0;
        clr();
        tick(); tick(); tick();
        check("post_reset_early", dv_n, 0);
        tick();
        check("post_reset_dv", digit_valid, 1);
        hold(4'b0111, S_DASH, 6);
        hold(4'b1011, S_3, 6);
        hold(4'b1101, S_0, 6);
        check("post_fv", fv_n, 1);
        check("post_frame", last_frame, 16'hDFA0);
        check("post_changed", last_fc, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
